rr_arb_mux: RTL

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_pkg.sv | 21 ++
 rtl/rr_arb_mux_if.sv | 29 ++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/rr_arb_mux.sv | 74 +++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Channel-index width: clog2(n), never narrower than one bit.
  function automatic int chw_f(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Bundles the per-channel input handshake and the registered output port.
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int CHW = chw_f(NCH);

  arb_mode_e              mode;
  logic [NCH-1:0]         in_valid;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [CHW-1:0]         out_ch;
  logic                   out_ready;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant: scan requests starting at 0 (fixed) or at ptr (round-robin), wrapping.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int  NCH = 4,
  localparam int CHW = chw_f(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  input  arb_mode_e      mode,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx
);

  logic [CHW-1:0] start_s;
  logic [CHW-1:0] cand_s;
  logic           found_s;

  function automatic logic [CHW-1:0] rot_f(input logic [CHW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCH) begin
      s = s - NCH;
    end else begin
      s = s;
    end
    return CHW'(s);
  endfunction

  // Choose the scan origin from the arbitration mode.
  always_comb begin
    start_s = {CHW{1'b0}};
    case (mode)
      ARB_RR:    start_s = ptr;
      ARB_FIXED: start_s = {CHW{1'b0}};
      default:   start_s = {CHW{1'b0}};
    endcase
  end

  // First requesting channel in scan order wins.
  always_comb begin
    gnt     = {NCH{1'b0}};
    gnt_idx = {CHW{1'b0}};
    found_s = 1'b0;
    cand_s  = {CHW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      cand_s = rot_f(start_s, k);
      if (!found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrating N:1 mux with a single registered output stage and a round-robin pointer.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input logic        clk,
  input logic        rst,
  rr_arb_mux_if.slave bus
);

  localparam int CHW = chw_f(NCH);

  logic [CHW-1:0]   ptr_r;
  logic [CHW-1:0]   ptr_next_s;
  logic [CHW-1:0]   gnt_idx_s;
  logic [NCH-1:0]   gnt_s;
  logic [NCH-1:0]   in_ready_s;
  logic             free_s;
  logic             take_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CHW-1:0]   out_ch_r;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_r),
    .mode    (bus.mode),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Grant is exposed only when the output stage can take a word and not in reset.
  always_comb begin
    free_s = !out_valid_r || bus.out_ready;
    if (!rst && free_s) begin
      in_ready_s = gnt_s;
    end else begin
      in_ready_s = {NCH{1'b0}};
    end
    take_s     = |in_ready_s;
    sel_data_s = bus.in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
    if (gnt_idx_s == CHW'(NCH-1)) begin
      ptr_next_s = {CHW{1'b0}};
    end else begin
      ptr_next_s = gnt_idx_s + CHW'(1);
    end
  end

  // Output register and pointer; a full stage that is being drained reloads in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ch_r    <= {CHW{1'b0}};
      ptr_r       <= {CHW{1'b0}};
    end else if (free_s) begin
      out_valid_r <= take_s;
      if (take_s) begin
        out_data_r <= sel_data_s;
        out_ch_r   <= gnt_idx_s;
        ptr_r      <= ptr_next_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;

endmodule
